// File: rtl/spi_pkg.sv
// spi_pkg: frame layout, register addresses and FSM states shared by SPI host and peripheral.
// Rev 1.0
`default_nettype none

package spi_pkg;

  localparam int FRAME_BITS = 32;
  localparam int ADDR_MSB   = 23;
  localparam int ADDR_LSB   = 16;
  localparam int DATA_MSB   = 15;
  localparam int BIT_CNT_W  = 6;

  localparam logic [7:0] RESET_ADDR = 8'h00;
  localparam logic [7:0] OP_ADDR    = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [ADDR_MSB-ADDR_LSB:0] addr,
    input logic [DATA_MSB:0]          data
  );
    logic [FRAME_BITS-1:0] f;
    f                   = '0;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[DATA_MSB:0]        = data;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_half_timer.sv
// spi_half_timer: counts HALF_PERIOD clocks after a load and flags the last one.
// Rev 1.0
`default_nettype none

module spi_half_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(HALF_PERIOD);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Expiry in the last clock of the window lets the FSM switch exactly HALF_PERIOD clocks after load.
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/spi_host_ctrl.sv
// spi_host_ctrl: SPI initiator for the 32-bit {8'h00, addr, data} frame, MSB first.
// Rev 1.0
`default_nettype none

module spi_host_ctrl #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic        cs_o
);

  import spi_pkg::*;

  spi_state_e            state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  cs_q;
  logic                  idle_first_q;
  logic [FRAME_BITS-1:0] tx_q;
  logic [FRAME_BITS-1:0] rx_q;
  logic [FRAME_BITS-1:0] rdata_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;

  logic [FRAME_BITS-1:0] frame_d;
  logic                  accept_d;
  logic                  load_d;
  logic                  expire;

  assign frame_d = build_frame(addr_i, data_i);
  // The first idle clock after a gap refuses requests so back-to-back frames stay separated.
  assign accept_d = (state_q == ST_IDLE) && start_i && !idle_first_q;
  assign load_d   = accept_d || (expire && (state_q != ST_GAP));

  spi_half_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_half_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load_d),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_q         <= 1'b1;
      idle_first_q <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      rdata_q      <= '0;
      bit_cnt_q    <= '0;
    end else begin
      done_q       <= 1'b0;
      idle_first_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            state_q   <= ST_SETUP;
            busy_q    <= 1'b1;
            cs_q      <= 1'b0;
            mosi_q    <= frame_d[FRAME_BITS-1];
            tx_q      <= {frame_d[FRAME_BITS-2:0], 1'b0};
            rx_q      <= '0;
            bit_cnt_q <= '0;
          end
        end
        ST_SETUP: begin
          if (expire) begin
            state_q <= ST_HIGH;
            sclk_q  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (expire) begin
            sclk_q    <= 1'b0;
            rx_q      <= {rx_q[FRAME_BITS-2:0], miso_i};
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            state_q   <= (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) ? ST_HOLD : ST_LOW;
          end
        end
        ST_LOW: begin
          // Rises 2..32 present the next bit; rise 1 reuses the bit set up at accept.
          if (expire) begin
            state_q <= ST_HIGH;
            sclk_q  <= 1'b1;
            mosi_q  <= tx_q[FRAME_BITS-1];
            tx_q    <= {tx_q[FRAME_BITS-2:0], 1'b0};
          end
        end
        ST_HOLD: begin
          if (expire) begin
            state_q <= ST_GAP;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= rx_q;
          end
        end
        ST_GAP: begin
          if (expire) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            idle_first_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign sclk_o  = sclk_q;
  assign mosi_o  = mosi_q;
  assign cs_o    = cs_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_host_ctrl.sv
// tb_spi_host_ctrl: two hosts (HALF_PERIOD 4 and 1) checked every cycle against a timing-formula model.
// Rev 1.0
`default_nettype none

module tb_spi_host_ctrl;

  import spi_pkg::*;

  localparam int H0 = 4;
  localparam int H1 = 1;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  start;
  logic [7:0]  addr [2];
  logic [15:0] data [2];
  logic [1:0]  busy, done, sclk, mosi, miso, cs;
  logic [31:0] rdata [2];

  spi_host_ctrl #(.HALF_PERIOD(H0)) u_dut4 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .addr_i(addr[0]), .data_i(data[0]),
    .busy_o(busy[0]), .done_o(done[0]), .rdata_o(rdata[0]), .sclk_o(sclk[0]),
    .mosi_o(mosi[0]), .miso_i(miso[0]), .cs_o(cs[0])
  );

  spi_host_ctrl #(.HALF_PERIOD(H1)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .addr_i(addr[1]), .data_i(data[1]),
    .busy_o(busy[1]), .done_o(done[1]), .rdata_o(rdata[1]), .sclk_o(sclk[1]),
    .mosi_o(mosi[1]), .miso_i(miso[1]), .cs_o(cs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (timing formulas per accepted frame) ----------------
  longint      cyc = 0;
  bit          m_active [2] = '{0, 0};
  longint      m_T      [2] = '{0, 0};
  longint      m_end    [2] = '{-100, -100};
  logic [31:0] m_frame  [2] = '{32'h0, 32'h0};
  logic [31:0] m_word   [2] = '{32'h0, 32'h0};
  logic [31:0] m_rdata  [2] = '{32'h0, 32'h0};
  logic [31:0] sl_word  [2];

  function automatic int hp(input int g);
    return (g == 0) ? H0 : H1;
  endfunction

  always @(posedge clk) begin
    longint e;
    cyc = cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        m_active[g] = 0;
        m_rdata[g]  = 32'h0;
        m_end[g]    = -100;
      end else if (m_active[g]) begin
        e = cyc - m_T[g] - 1;
        if (e == 65 * hp(g)) m_rdata[g] = m_word[g];
        if (e == 66 * hp(g)) begin
          m_active[g] = 0;
          m_end[g]    = cyc;
        end
      end else if (start[g] && (cyc - 1 != m_end[g])) begin
        m_active[g] = 1;
        m_T[g]      = cyc - 1;
        m_frame[g]  = {8'h00, addr[g], data[g]};
        m_word[g]   = sl_word[g];
      end
    end
  end

  // {busy, done, cs, sclk, mosi, rdata}
  function automatic logic [36:0] expect_out(input int g);
    int     h;
    longint e, rises;
    int     b;
    logic   ex_done, ex_cs, ex_sclk, ex_mosi;
    h = hp(g);
    if (!m_active[g]) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_rdata[g]};
    e       = cyc - m_T[g] - 1;
    ex_done = (e == 65 * h);
    ex_cs   = (e >= 65 * h);
    ex_sclk = (e >= h) && (e < 64 * h) && ((((e - h) / h) % 2) == 0);
    rises   = (e < h) ? 0 : ((e - h) / (2 * h) + 1);
    if (rises > 32) rises = 32;
    b       = (rises <= 1) ? 31 : int'(32 - rises);
    ex_mosi = (e < 65 * h) ? m_frame[g][b] : 1'b0;
    return {1'b1, ex_done, ex_cs, ex_sclk, ex_mosi, m_rdata[g]};
  endfunction

  // ---------------- compare process + bench slave ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          all_done = 0;
  string       lit_name [$];
  longint      lit_act  [$];
  longint      lit_exp  [$];

  logic [1:0]  prev_sclk = 2'b00, prev_cs = 2'b11, prev_busy = 2'b00;
  logic [31:0] s_rx [2], s_last_rx [2];
  int          s_idx [2] = '{0, 0}, s_rises [2] = '{0, 0}, s_falls [2] = '{0, 0};
  int          s_last_rises [2] = '{0, 0}, s_high [2] = '{0, 0}, s_edges [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  longint      done_cyc [2], fall_cyc [2], cs_fall_cyc [2], first_rise [2], last_fall [2];

  initial miso = 2'b00;

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  always @(negedge clk) begin
    logic [36:0] act, exp_v;
    logic [31:0] w;
    if (cyc >= 1) begin
      for (int g = 0; g < 2; g++) begin
        act   = {busy[g], done[g], cs[g], sclk[g], mosi[g], rdata[g]};
        exp_v = expect_out(g);
        n_cmp = n_cmp + 1;
        if (act !== exp_v) begin
          n_bad = n_bad + 1;
          $display("FAIL outputs_h%0d cycle %0d: got %h want %h {busy,done,cs,sclk,mosi,rdata}",
                   hp(g), cyc, act, exp_v);
        end
        if (prev_cs[g] && !cs[g]) begin
          s_rx[g] = 32'h0; s_idx[g] = 0; s_rises[g] = 0; s_falls[g] = 0; s_high[g] = 0;
          cs_fall_cyc[g] = cyc;
        end
        if (!prev_cs[g] && cs[g]) begin
          s_last_rx[g]    = s_rx[g];
          s_last_rises[g] = s_rises[g];
        end
        if (sclk[g] && !prev_sclk[g]) begin
          s_edges[g] = s_edges[g] + 1;
          s_rises[g] = s_rises[g] + 1;
          if (s_rises[g] == 1) first_rise[g] = cyc;
          w       = m_word[g];
          miso[g] = w[31 - s_idx[g]];
          if (s_idx[g] < 31) s_idx[g] = s_idx[g] + 1;
        end
        if (!sclk[g] && prev_sclk[g]) begin
          s_edges[g]   = s_edges[g] + 1;
          s_falls[g]   = s_falls[g] + 1;
          last_fall[g] = cyc;
          s_rx[g]      = {s_rx[g][30:0], mosi[g]};
        end
        if (!cs[g] && sclk[g]) s_high[g] = s_high[g] + 1;
        if (done[g]) begin
          done_cyc[g] = cyc;
          done_cnt[g] = done_cnt[g] + 1;
        end
        if (prev_busy[g] && !busy[g]) fall_cyc[g] = cyc;
      end
      prev_sclk = sclk;
      prev_cs   = cs;
      prev_busy = busy;
    end
    if (all_done) begin
      for (int i = 0; i < lit_name.size(); i++) begin
        n_cmp = n_cmp + 1;
        if (lit_act[i] != lit_exp[i]) begin
          n_bad = n_bad + 1;
          $display("FAIL %s: got 0x%0h want 0x%0h", lit_name[i], lit_act[i], lit_exp[i]);
        end
      end
      summary_and_finish();
    end else if (n_bad >= 50) begin
      summary_and_finish();
    end else if (cyc > 40000) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL watchdog: got cycle %0d want completion before 40000", cyc);
      summary_and_finish();
    end
  end

  // ---------------- stimulus ----------------
  longint t;
  int     n0, e0;

  task automatic rec(input string n, input longint a, input longint e);
    lit_name.push_back(n);
    lit_act.push_back(a);
    lit_exp.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cyc(input longint target);
    while (cyc < target) tick();
  endtask

  task automatic do_frame(input int g, input logic [7:0] a, input logic [15:0] d,
                          input logic [31:0] w, output longint t_acc);
    addr[g] = a; data[g] = d; sl_word[g] = w; start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    t_acc    = cyc - 1;
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    int base = done_cnt[g];
    while (done_cnt[g] == base && n < 400) begin tick(); n++; end
    if (done_cnt[g] == base) rec("timeout_waiting_done", 0, 1);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] !== 1'b0 && n < 400) begin tick(); n++; end
    if (busy[g] !== 1'b0) rec("timeout_waiting_idle", 0, 1);
    tick();
  endtask

  initial begin
    rst = 2'b11; start = 2'b00;
    addr = '{8'h0, 8'h0}; data = '{16'h0, 16'h0}; sl_word = '{32'h0, 32'h0};
    repeat (3) tick();
    rst = 2'b00;
    e0 = s_edges[0] + s_edges[1];
    repeat (50) tick();
    rec("idle_no_sclk_edges", s_edges[0] + s_edges[1] - e0, 0);
    rec("idle_cs", cs[0], 1);
    rec("idle_busy", busy[0], 0);
    rec("idle_rdata", rdata[0], 0);

    // operand write + readback, H=4
    do_frame(0, OP_ADDR, 16'h0305, 32'hA5C30F96, t);
    wait_done(0);
    rec("h4_done_at_T+261", done_cyc[0] - t, 261);
    rec("h4_rdata", rdata[0], 32'hA5C30F96);
    rec("h4_slave_rx", s_last_rx[0], 32'h00010305);
    rec("h4_rises", s_last_rises[0], 32);
    rec("h4_sclk_high_cycles", s_high[0], 128);
    rec("h4_rise1_to_fall32", last_fall[0] - first_rise[0], 252);
    wait_idle(0);
    rec("h4_busy_low_at_T+265", fall_cyc[0] - t, 265);
    repeat (20) tick();
    rec("h4_rdata_held", rdata[0], 32'hA5C30F96);

    // start while busy / at the busy-fall cycle / one cycle later
    do_frame(0, 8'h3C, 16'hBEEF, 32'h12345678, t);
    wait_cyc(t + 5);   start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_cyc(t + 200); start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_cyc(t + 265);
    addr[0] = 8'h01; data[0] = 16'h0777; sl_word[0] = 32'h0F0F1E1E;
    start[0] = 1'b1; tick(); tick(); start[0] = 1'b0;
    tick();
    rec("frame2_cs_low_at_T+267", cs_fall_cyc[0] - t, 267);
    wait_done(0);
    rec("frame2_slave_rx", s_last_rx[0], 32'h00010777);
    rec("frame2_rdata", rdata[0], 32'h0F0F1E1E);
    wait_idle(0);

    // reset mid-frame after the 10th fall
    do_frame(0, 8'h55, 16'hAAAA, 32'hDEADBEEF, t);
    tick();
    n0 = 0;
    while (s_falls[0] < 10 && n0 < 400) begin tick(); n0++; end
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    rec("abort_cs", cs[0], 1);
    rec("abort_sclk", sclk[0], 0);
    rec("abort_rdata", rdata[0], 0);
    n0 = done_cnt[0];
    repeat (300) tick();
    rec("abort_no_done", done_cnt[0] - n0, 0);
    do_frame(0, RESET_ADDR, 16'h0001, 32'h80000001, t);
    wait_done(0);
    rec("after_abort_slave_rx", s_last_rx[0], 32'h00000001);
    rec("after_abort_rdata", rdata[0], 32'h80000001);
    wait_idle(0);

    // HALF_PERIOD = 1
    do_frame(1, OP_ADDR, 16'h0305, 32'hA5C30F96, t);
    wait_done(1);
    rec("h1_done_at_T+66", done_cyc[1] - t, 66);
    rec("h1_rdata", rdata[1], 32'hA5C30F96);
    rec("h1_slave_rx", s_last_rx[1], 32'h00010305);
    rec("h1_sclk_high_cycles", s_high[1], 32);
    rec("h1_rise1_to_fall32", last_fall[1] - first_rise[1], 63);
    wait_idle(1);
    rec("h1_busy_low_at_T+67", fall_cyc[1] - t, 67);

    // randomized traffic on both hosts, including stray starts and rare resets
    for (int i = 0; i < 3000; i++) begin
      for (int g = 0; g < 2; g++) begin
        start[g]   = ($urandom_range(7) == 0);
        rst[g]     = ($urandom_range(799) == 0);
        addr[g]    = 8'($urandom);
        data[g]    = 16'($urandom);
        sl_word[g] = $urandom;
      end
      tick();
    end
    start = 2'b00; rst = 2'b00;
    wait_idle(0);
    wait_idle(1);
    all_done = 1;
  end

endmodule

`default_nettype wire
